// File: rtl/sdram_burst_pkg.sv
// Shared definitions for the SDRAM burst column-address sequencer:
// burst-length codes, addressing modes and FSM state encoding.
package sdram_burst_pkg;

    // Burst-length codes carried on the BurstLength input (4..6 reserved)
    localparam logic [2:0] BL1    = 3'd0;
    localparam logic [2:0] BL2    = 3'd1;
    localparam logic [2:0] BL4    = 3'd2;
    localparam logic [2:0] BL8    = 3'd3;
    localparam logic [2:0] BLPAGE = 3'd7;

    // Addressing modes
    localparam logic SEQ   = 1'b0;
    localparam logic INTLV = 1'b1;

    // Sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

endpackage

// File: rtl/burst_mask_gen.sv
// Burst-length code to carry-mask decoder. The mask selects the column
// bits that wrap inside the burst boundary; it also equals L-1, which the
// sequencer uses to detect the last beat. Reserved codes give a zero mask
// and a cleared valid flag.
module burst_mask_gen
    import sdram_burst_pkg::*;
#(
    parameter int COL_W = 8
) (
    input  logic [2:0]       i_code,
    output logic [COL_W-1:0] o_mask,
    output logic             o_valid
);

    // Decode the burst-length code into its wrap mask and validity
    always_comb begin
        o_mask  = {COL_W{1'b0}};
        o_valid = 1'b0;
        case (i_code)
            BL1: begin
                o_mask  = {COL_W{1'b0}};
                o_valid = 1'b1;
            end
            BL2: begin
                o_mask  = {{(COL_W-1){1'b0}}, 1'b1};
                o_valid = 1'b1;
            end
            BL4: begin
                o_mask  = {{(COL_W-2){1'b0}}, 2'b11};
                o_valid = 1'b1;
            end
            BL8: begin
                o_mask  = {{(COL_W-3){1'b0}}, 3'b111};
                o_valid = 1'b1;
            end
            BLPAGE: begin
                o_mask  = {COL_W{1'b1}};
                o_valid = 1'b1;
            end
            default: begin
                o_mask  = {COL_W{1'b0}};
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/burst_addr_sequencer.sv
// SDRAM burst column-address sequencer. Latches start column, burst length
// and addressing mode, then steps one column address per consumed beat,
// wrapping within the burst boundary. Supports gapless back-to-back bursts
// and early termination. All outputs are registered.
module burst_addr_sequencer
    import sdram_burst_pkg::*;
#(
    parameter int COL_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [COL_W-1:0] i_start_addr,
    input  logic [2:0]       i_burst_length,
    input  logic             i_addr_mode,
    input  logic             i_advance,
    input  logic             i_terminate,
    output logic [COL_W-1:0] o_col_addr,
    output logic             o_addr_valid,
    output logic             o_busy,
    output logic             o_burst_done,
    output logic             o_error
);

    burst_state_t     r_state, w_state_nxt;
    logic [COL_W-1:0] r_base, w_base_nxt;
    logic [COL_W-1:0] r_mask, w_mask_nxt;
    logic             r_mode, w_mode_nxt;
    logic [COL_W:0]   r_count, w_count_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic [COL_W-1:0] w_start_mask;
    logic             w_code_ok;
    logic             w_start_mode;
    logic [COL_W-1:0] w_step_n;
    logic [COL_W-1:0] w_seq_addr;
    logic [COL_W-1:0] w_intlv_addr;
    logic [COL_W-1:0] w_step_addr;
    logic             w_last_beat;

    burst_mask_gen #(
        .COL_W (COL_W)
    ) u_mask_gen (
        .i_code  (i_burst_length),
        .o_mask  (w_start_mask),
        .o_valid (w_code_ok)
    );

    // Full-page bursts always walk sequentially, whatever the mode input says
    assign w_start_mode = (i_burst_length == BLPAGE) ? SEQ : i_addr_mode;

    // Address for the beat after the current one; bits outside the mask stay fixed
    assign w_step_n     = r_count[COL_W-1:0] + {{(COL_W-1){1'b0}}, 1'b1};
    assign w_seq_addr   = (r_base & ~r_mask) | ((r_base + w_step_n) & r_mask);
    assign w_intlv_addr = (r_base & ~r_mask) | ((r_base ^ w_step_n) & r_mask);
    assign w_step_addr  = (r_mode == INTLV) ? w_intlv_addr : w_seq_addr;

    // Mask equals L-1, so the last beat is reached when the count matches it
    assign w_last_beat  = (r_count == {1'b0, r_mask});

    // Next-state, counter and output decode; pulses default low every cycle
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_mask_nxt  = r_mask;
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        w_col_nxt   = r_col;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && w_code_ok) begin
                    w_state_nxt = ST_BURST;
                    w_base_nxt  = i_start_addr;
                    w_mask_nxt  = w_start_mask;
                    w_mode_nxt  = w_start_mode;
                    w_count_nxt = {(COL_W+1){1'b0}};
                    w_col_nxt   = i_start_addr;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_err_nxt   = i_start;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end
            ST_BURST: begin
                if (i_terminate) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = {(COL_W+1){1'b0}};
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else if (i_advance) begin
                    if (w_last_beat) begin
                        w_done_nxt = 1'b1;
                        if (i_start && w_code_ok) begin
                            w_state_nxt = ST_BURST;
                            w_base_nxt  = i_start_addr;
                            w_mask_nxt  = w_start_mask;
                            w_mode_nxt  = w_start_mode;
                            w_count_nxt = {(COL_W+1){1'b0}};
                            w_col_nxt   = i_start_addr;
                            w_valid_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_err_nxt   = i_start;
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = {(COL_W+1){1'b0}};
                            w_valid_nxt = 1'b0;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_count_nxt = r_count + {{COL_W{1'b0}}, 1'b1};
                        w_col_nxt   = w_step_addr;
                    end
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = {(COL_W+1){1'b0}};
                w_col_nxt   = {COL_W{1'b0}};
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_base  <= {COL_W{1'b0}};
            r_mask  <= {COL_W{1'b0}};
            r_mode  <= SEQ;
            r_count <= {(COL_W+1){1'b0}};
            r_col   <= {COL_W{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_mask  <= w_mask_nxt;
            r_mode  <= w_mode_nxt;
            r_count <= w_count_nxt;
            r_col   <= w_col_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_col_addr   = r_col;
    assign o_addr_valid = r_valid;
    assign o_busy       = r_busy;
    assign o_burst_done = r_done;
    assign o_error      = r_err;

endmodule

// File: tb/tb_burst_addr_sequencer.sv
// Directed self-checking bench for burst_addr_sequencer (COL_W = 8).
// Inputs change and outputs are observed on the falling clock edge.
// Observed vector layout: {ColAddr[7:0], AddrValid, Busy, BurstDone, Error}.
module tb_burst_addr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [2:0] burst_length = 3'd0;
    logic       addr_mode = 1'b0;
    logic       advance = 1'b0;
    logic       terminate = 1'b0;
    logic [7:0] col_addr;
    logic       addr_valid, busy, burst_done, error;
    logic [11:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {col_addr, addr_valid, busy, burst_done, error};

    burst_addr_sequencer #(.COL_W(8)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_start        (start),
        .i_start_addr   (start_addr),
        .i_burst_length (burst_length),
        .i_addr_mode    (addr_mode),
        .i_advance      (advance),
        .i_terminate    (terminate),
        .o_col_addr     (col_addr),
        .o_addr_valid   (addr_valid),
        .o_busy         (busy),
        .o_burst_done   (burst_done),
        .o_error        (error)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        logic [11:0] exp_v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_v = {8'h00, 4'b0000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, exp_v);
        end
        reset = 1'b0;
        terminate = 1'b1;
        @(negedge clk);
        terminate = 1'b0;
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_bl8(input logic mode);
        logic [7:0] seq_t [8] = '{8'h05, 8'h06, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] int_t [8] = '{8'h05, 8'h04, 8'h07, 8'h06, 8'h01, 8'h00, 8'h03, 8'h02};
        logic [7:0] last_c;
        logic [11:0] exp_v;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h05; burst_length = 3'd3; addr_mode = mode; advance = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_v = {(mode ? int_t[k] : seq_t[k]), 4'b1100};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL bl8_mode%0d_beat%0d: got %h expected %h", mode, k, obs, exp_v);
            end
        end
        last_c = mode ? 8'h02 : 8'h04;
        @(negedge clk);
        advance = 1'b0;
        exp_v = {last_c, 4'b0010};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bl8_mode%0d_done: got %h expected %h", mode, obs, exp_v);
        end
        @(negedge clk);
        exp_v = {last_c, 4'b0000};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL bl8_mode%0d_idle: got %h expected %h", mode, obs, exp_v);
        end
    endtask

    task automatic test_advance_stall();
        logic [11:0] exp_t [8] = '{{8'h0E, 4'b1100}, {8'h0F, 4'b1100}, {8'h0F, 4'b1100},
                                   {8'h0F, 4'b1100}, {8'h0C, 4'b1100}, {8'h0D, 4'b1100},
                                   {8'h0D, 4'b0010}, {8'h0D, 4'b0000}};
        logic adv_t [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        @(negedge clk);
        start = 1'b1; start_addr = 8'h0E; burst_length = 3'd2; addr_mode = 1'b0; advance = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got %h expected %h", k, obs, exp_t[k]);
            end
            advance = adv_t[k];
        end
    endtask

    task automatic test_terminate();
        logic [11:0] exp_t [8] = '{{8'h10, 4'b1100}, {8'h11, 4'b1100}, {8'h12, 4'b1100},
                                   {8'h13, 4'b1100}, {8'h13, 4'b0000}, {8'h20, 4'b1100},
                                   {8'h20, 4'b0010}, {8'h20, 4'b0000}};
        @(negedge clk);
        start = 1'b1; start_addr = 8'h10; burst_length = 3'd3; addr_mode = 1'b0; advance = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL terminate_cycle%0d: got %h expected %h", k, obs, exp_t[k]);
            end
            if (k == 3) begin
                terminate = 1'b1;
            end
            if (k == 4) begin
                start = 1'b1; start_addr = 8'h20; burst_length = 3'd0; advance = 1'b0;
            end
            if (k == 5) begin
                terminate = 1'b0; advance = 1'b1;
            end
            if (k == 6) begin
                advance = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_t [5] = '{{8'h30, 4'b1100}, {8'h31, 4'b1100}, {8'h40, 4'b1110},
                                   {8'h40, 4'b0010}, {8'h40, 4'b0000}};
        @(negedge clk);
        start = 1'b1; start_addr = 8'h30; burst_length = 3'd1; addr_mode = 1'b0; advance = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", k, obs, exp_t[k]);
            end
            if (k == 1) begin
                start = 1'b1; start_addr = 8'h40; burst_length = 3'd0;
            end
            if (k == 3) begin
                advance = 1'b0;
            end
        end
    endtask

    task automatic test_reserved_code();
        logic [11:0] exp_t [5] = '{{8'h40, 4'b0001}, {8'h40, 4'b0000}, {8'h60, 4'b1100},
                                   {8'h60, 4'b0011}, {8'h60, 4'b0000}};
        @(negedge clk);
        start = 1'b1; start_addr = 8'h55; burst_length = 3'd5; addr_mode = 1'b0; advance = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL reserved_cycle%0d: got %h expected %h", k, obs, exp_t[k]);
            end
            if (k == 1) begin
                start = 1'b1; start_addr = 8'h60; burst_length = 3'd0;
            end
            if (k == 2) begin
                start = 1'b1; start_addr = 8'h70; burst_length = 3'd6; advance = 1'b1;
            end
            if (k == 3) begin
                advance = 1'b0;
            end
        end
    endtask

    task automatic test_full_page();
        logic [7:0]  c;
        logic [11:0] exp_v;
        @(negedge clk);
        start = 1'b1; start_addr = 8'h80; burst_length = 3'd7; addr_mode = 1'b0; advance = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            start = 1'b0;
            c = 8'h80 + 8'(i);
            exp_v = {c, 4'b1100};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL page_beat%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        @(negedge clk);
        advance = 1'b0;
        exp_v = {8'h7F, 4'b0010};
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL page_done: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_page();
        logic [11:0] exp_t [6] = '{{8'hFE, 4'b1100}, {8'hFF, 4'b1100}, {8'h00, 4'b1100},
                                   {8'h01, 4'b1100}, {8'h00, 4'b0000}, {8'h00, 4'b0000}};
        @(negedge clk);
        start = 1'b1; start_addr = 8'hFE; burst_length = 3'd7; addr_mode = 1'b1; advance = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs !== exp_t[k]) begin
                n_fail++;
                $display("FAIL reset_mid_cycle%0d: got %h expected %h", k, obs, exp_t[k]);
            end
            if (k == 2) begin
                start = 1'b1; start_addr = 8'h99; burst_length = 3'd0;
            end
            if (k == 3) begin
                reset = 1'b1;
            end
            if (k == 4) begin
                reset = 1'b0; advance = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_bl8(1'b0);
        test_bl8(1'b1);
        test_advance_stall();
        test_terminate();
        test_back_to_back();
        test_reserved_code();
        test_full_page();
        test_reset_mid_page();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/burst_addr_sequencer.md
Name: burst_addr_sequencer

Overview:
- Sequences SDRAM column addresses for one read/write burst.
- Latches start column, burst-length code and addressing mode, then emits one column address per accepted beat.
- Wraps within the burst boundary using a carry mask: bits inside the mask change, bits outside stay fixed.
- Sits between the command scheduler and the column-address driver of the SDRAM controller.

Parameters:
- COL_W, 8, column address width in bits (4..12).

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request to begin a burst; sampled only when accepted (see Behaviour).
- StartAddr  in  COL_W  first column address of the burst.
- BurstLength  in  3  0=1 beat, 1=2, 2=4, 3=8, 7=full page (2^COL_W beats); 4..6 reserved.
- AddrMode  in  1  0=sequential, 1=interleaved.
- Advance  in  1  current beat consumed by the data path; the address steps only when this is 1.
- Terminate  in  1  burst-terminate request.
- ColAddr  out  COL_W  current column address (registered).
- AddrValid  out  1  ColAddr is valid.
- Busy  out  1  burst in progress.
- BurstDone  out  1  one-cycle pulse when the last beat is consumed.
- Error  out  1  one-cycle pulse when Start carries a reserved BurstLength.

Behaviour:
- Reset (synchronous): state IDLE; ColAddr=0, AddrValid=0, Busy=0, BurstDone=0, Error=0, beat counter=0. Reset has priority over every input, including mid-burst; no BurstDone is issued.
- States: IDLE, BURST.
- Mask per code: 0→0, 1→0x1, 2→0x3, 3→0x7, 7→all ones. Stored with the burst.
- Address with beat count n, base B = StartAddr:
  - Sequential: ColAddr = (B & ~M) | ((B + n) & M).
  - Interleaved: ColAddr = (B & ~M) | ((B ^ n) & M).
  - Full page with AddrMode=1 is treated as sequential.
- Beat counter is COL_W+1 bits wide. Burst length L = 1, 2, 4, 8 or 2^COL_W.
- Start accepted in IDLE with a valid code:
  - Next cycle: BURST, Busy=1, AddrValid=1, ColAddr=StartAddr, n=0.
  - Start-to-first-address latency is 1 cycle.
- Start in IDLE with code 4..6: Error=1 for one cycle, stay IDLE, nothing latched.
- In BURST, Advance=1 and n<L-1: n increments; ColAddr updates the next cycle.
- In BURST, Advance=0: all outputs hold.
- In BURST, Advance=1 and n=L-1:
  - BurstDone=1 next cycle.
  - No Start this cycle: IDLE, AddrValid=0, Busy=0.
  - Start=1 with a valid code: gapless back-to-back. New burst latched, ColAddr=new StartAddr next cycle, Busy stays 1, BurstDone still pulses.
  - Start=1 with a reserved code: Error pulses and the block returns to IDLE.
- Start in BURST other than on the last consumed beat is ignored.
- Terminate in BURST has priority over Advance and Start:
  - Next cycle: IDLE, AddrValid=0, Busy=0.
  - No BurstDone.
- Terminate in IDLE is ignored.
- BL=1 burst: one address; BurstDone follows the first Advance.
- Full page: ColAddr wraps from 2^COL_W-1 to 0 and ends after 2^COL_W advances.

Decomposition:
- Shared package sdram_burst_pkg:
  - BurstLength code constants (BL1, BL2, BL4, BL8, BLPAGE).
  - AddrMode constants (SEQ, INTLV).
  - State encoding for IDLE and BURST.
- Sub-module burst_mask_gen: combinational code→mask plus valid-code flag, parameterised by COL_W.
- FSM, counter and address arithmetic stay in burst_addr_sequencer.

Test Plan:
- COL_W=8, Start, StartAddr=0x05, BL=3, AddrMode=0, Advance held at 1 → ColAddr 05,06,07,00,01,02,03,04 on consecutive cycles; BurstDone on the cycle after 04 is consumed; then AddrValid=0.
- Same with AddrMode=1 → ColAddr 05,04,07,06,01,00,03,02.
- StartAddr=0x0E, BL=2, sequential, Advance low on beats 1–2 → sequence 0E,0F,0C,0D; ColAddr holds 0F while Advance=0; BurstDone only once.
- BL=3 burst from 0x10, Terminate asserted at n=3 → returns to IDLE next cycle, no BurstDone; then a BL=1 Start at 0x20 gives a single address 20 followed by BurstDone.
- Back-to-back: second Start (0x40, BL=1) on the last beat of a BL=2 burst from 0x30 → 30,31,40 with no gap; Busy stays 1; BurstDone pulses twice.
- Start with BL=5 → Error one cycle, Busy=0. Separately, Reset mid-burst of a full-page burst → all outputs 0 next cycle, no BurstDone.
